// File: rtl/pkt_rx_buffer.sv
// Packet buffer behind the parser: stores whole FAST-format packets in a circular
// word RAM and releases only committed packets to the consumer.
module pkt_rx_buffer #(
    parameter int DEPTH_LOG2 = 8,
    parameter int PKT_LOG2   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_in_valid,
    input  logic [133:0]        data_in,
    output logic                out_valid,
    output logic [133:0]        out_data,
    input  logic                out_ready,
    output logic [PKT_LOG2:0]   pkt_count,
    output logic [DEPTH_LOG2:0] free_words,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    err_cnt
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int CW = PKT_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH   = PW'(1) << DEPTH_LOG2;
    localparam logic [CW-1:0] PKT_MAX = CW'(1) << PKT_LOG2;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_tmp_q, wr_tmp_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [133:0]     out_data_q, out_data_d;
    logic [133:0]     mem [2**DEPTH_LOG2];

    logic [1:0]    tag;
    logic [PW-1:0] base;
    logic          we, commit, drop_inc, err_inc, restart, full, pkt_full, accept;

    assign tag      = data_in[133:132];
    assign pkt_full = (pkt_count_q == PKT_MAX);

    // Write side: base is where the current word lands (wr_cmt after a rollback).
    always_comb begin
        state_d  = state_q;
        wr_tmp_d = wr_tmp_q;
        wr_cmt_d = wr_cmt_q;
        we       = 1'b0;
        commit   = 1'b0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        restart  = 1'b0;
        base     = wr_tmp_q;
        full     = 1'b0;
        if (data_in_valid) begin
            case (state_q)
                RECV: begin
                    if (tag[0]) begin
                        base     = wr_cmt_q;
                        wr_tmp_d = wr_cmt_q;
                        err_inc  = 1'b1;
                        restart  = 1'b1;
                        state_d  = IDLE;
                    end
                end
                DROP: begin
                    if (tag == T_TAIL) state_d = IDLE;
                    else if (tag[0])   restart = 1'b1;
                end
                default: restart = 1'b1;
            endcase
            full = ((base - rd_ptr_q) == DEPTH);
            if (state_q == RECV && !restart) begin
                if (full) begin
                    wr_tmp_d = wr_cmt_q;
                    drop_inc = 1'b1;
                    state_d  = (tag == T_TAIL) ? IDLE : DROP;
                end else begin
                    we       = 1'b1;
                    wr_tmp_d = base + PW'(1);
                    if (tag == T_TAIL) begin
                        wr_cmt_d = base + PW'(1);
                        commit   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            if (restart) begin
                case (tag)
                    T_HEAD: begin
                        if (pkt_full || full) begin
                            drop_inc = 1'b1;
                            state_d  = DROP;
                        end else begin
                            we       = 1'b1;
                            wr_tmp_d = base + PW'(1);
                            state_d  = RECV;
                        end
                    end
                    T_SINGLE: begin
                        state_d = IDLE;
                        if (pkt_full || full) begin
                            drop_inc = 1'b1;
                        end else begin
                            we       = 1'b1;
                            wr_tmp_d = base + PW'(1);
                            wr_cmt_d = base + PW'(1);
                            commit   = 1'b1;
                        end
                    end
                    default: begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Read side: rd_ptr names the word held in the output register; the RAM is
    // read at the pointer it will hold next, so an accept streams without bubbles.
    always_comb begin
        accept      = out_valid_q && out_ready;
        rd_ptr_d    = rd_ptr_q + PW'(accept);
        out_valid_d = (rd_ptr_d != wr_cmt_q);
        out_data_d  = out_valid_d ? mem[rd_ptr_d[DEPTH_LOG2-1:0]] : out_data_q;
        pkt_count_d = pkt_count_q + CW'(commit) - CW'(accept && out_data_q[133]);
        drop_cnt_d  = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
        err_cnt_d   = (err_inc && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (we) mem[base[DEPTH_LOG2-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_tmp_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_tmp_q    <= wr_tmp_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign pkt_count  = pkt_count_q;
    assign free_words = DEPTH - (wr_tmp_q - rd_ptr_q);
    assign drop_cnt   = drop_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: doc/pkt_rx_buffer.md
Name: pkt_rx_buffer

Overview:
- Packet buffer directly downstream of the TCP/MAC-filter parser stage.
- Accepts 134-bit FAST-format words (bits [133:132]: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single-word packet) and stores whole packets in a circular word RAM.
- Releases only complete packets to the CPU-side consumer over a valid/ready interface.
- Drops whole packets on overflow or framing errors; no partial packet ever reaches the consumer.

Parameters:
- DEPTH_LOG2, 8, log2 of word RAM depth (256 words x 134 bits).
- PKT_LOG2, 4, log2 of the maximum number of committed packets held (16).
- CNT_W, 16, width of the drop and error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in_valid  in  1  input word strobe; no backpressure upstream.
- data_in  in  134  FAST word.
- out_valid  out  1  out_data holds a committed word.
- out_data  out  134  word to consumer.
- out_ready  in  1  consumer accepts the word this cycle.
- pkt_count  out  PKT_LOG2+1  committed packets not yet fully read.
- free_words  out  DEPTH_LOG2+1  DEPTH minus (wr_tmp - rd_ptr).
- drop_cnt  out  CNT_W  packets dropped for lack of space; saturating.
- err_cnt  out  CNT_W  framing errors; saturating.

Behaviour:
- Reset values: out_valid=0, out_data=0, pkt_count=0, free_words=DEPTH, drop_cnt=0, err_cnt=0. All pointers are 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-packet; partially written packets are lost.
- Pointers are DEPTH_LOG2+1 bits with natural wrap-around:
  - wr_tmp: speculative write pointer.
  - wr_cmt: committed write pointer.
  - rd_ptr: read pointer.
  - Buffer full when wr_tmp - rd_ptr == DEPTH.
- Write FSM states: IDLE, RECV, DROP.
- IDLE:
  - Head (01): if pkt_count + pending == 2^PKT_LOG2 or the buffer is full, go to DROP and increment drop_cnt. Otherwise write the word at wr_tmp, increment wr_tmp, go to RECV.
  - Single (11): if space is available, write it and commit the same cycle, then stay in IDLE. Otherwise increment drop_cnt.
  - Body or tail: discard, increment err_cnt.
- RECV:
  - Body: write and advance wr_tmp. If the buffer is full, roll back wr_tmp to wr_cmt, increment drop_cnt, go to DROP.
  - Tail: write and advance wr_tmp, set wr_cmt to the new wr_tmp, go to IDLE. The same full rule applies: a tail arriving when full means drop, then IDLE.
  - Head or single (missing tail): roll back wr_tmp to wr_cmt, increment err_cnt, then treat the word exactly as in IDLE in the same cycle.
- DROP: discard words until a tail, then go to IDLE. A head in DROP is treated as in IDLE, with no extra error counted.
- data_in_valid=0 holds state in every FSM state; there is no timeout.
- Commit timing: tail (or single) written in cycle N → wr_cmt updated at N+1 → out_valid=1 with the packet's first word at N+2 (RAM read latency 1, output register).
- Read side:
  - out_valid=1 whenever rd_ptr != wr_cmt, with the output register filled.
  - out_data is held stable while out_valid && !out_ready.
  - On out_valid && out_ready, the next word is presented the next cycle (full throughput, prefetch register); if rd_ptr == wr_cmt afterwards, out_valid drops.
- pkt_count:
  - +1 on commit.
  - -1 on acceptance of a word with tag 10 or 11.
  - Both events in the same cycle leave it unchanged.
  - pending = 1 while in RECV.
- Simultaneous write and read to the same RAM address cannot occur, because reads never pass wr_cmt.
- Counters saturate at all-ones.

Test Plan:
- Reset, then 4-word packet (01, 00, 00, 10) with out_ready=1 → out_valid rises 2 cycles after the tail; 4 words out consecutively, identical to input; pkt_count goes 1 then 0; free_words returns to 256.
- out_ready=0 during a 3-word packet, then 1 → out_data is held on the head word until ready; words delivered in order, none duplicated.
- Fill with 250 words committed, then send a 10-word packet → it is dropped; drop_cnt=1; free_words=6 after the tail; a following 3-word packet is accepted and output.
- Head, body, then a new head with no tail → err_cnt=1; the first packet never appears; the second packet (ending in a tail) is output intact.
- 16 single-word (11) packets with out_ready=0, then a 17th → pkt_count=16, drop_cnt=1; set ready → exactly 16 words out.
- Assert rst_n=0 mid-packet during output → out_valid=0 and all counters 0 immediately; a fresh packet after release works normally.
